// File: rtl/mem_access_sequencer_if.sv
// Pipeline-side request/result signals and Wishbone-style data-memory bus of the MEM-stage sequencer.
// The master modport is the sequencer's view; the slave modport is the pipeline/memory side.
interface mem_access_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    localparam int LANES = DATA_W / 8;

    logic              stall;
    logic              req_valid;
    logic              req_indirect;
    logic              req_we;
    logic              req_byte;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              wb_CYC;
    logic              wb_STB;
    logic              wb_WE;
    logic [ADDR_W-1:0] wb_ADR;
    logic [LANES-1:0]  wb_SEL;
    logic [DATA_W-1:0] wb_DAT_O;
    logic [DATA_W-1:0] wb_DAT_I;
    logic              wb_ACK;
    logic              wb_RTY;

    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              error;
    logic              request_stall;

    modport master (
        input  stall, req_valid, req_indirect, req_we, req_byte, req_addr, req_wdata,
        input  wb_DAT_I, wb_ACK, wb_RTY,
        output wb_CYC, wb_STB, wb_WE, wb_ADR, wb_SEL, wb_DAT_O,
        output rdata, done, error, request_stall
    );

    modport slave (
        output stall, req_valid, req_indirect, req_we, req_byte, req_addr, req_wdata,
        output wb_DAT_I, wb_ACK, wb_RTY,
        input  wb_CYC, wb_STB, wb_WE, wb_ADR, wb_SEL, wb_DAT_O,
        input  rdata, done, error, request_stall
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// LC-3b MEM-stage data-memory master: optional pointer phase, then data phase, with RTY
// retry/backoff and ACK timeout; holds the pipeline until the result is ready.
module mem_access_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MAX_RETRY   = 4,
    parameter int BACKOFF_CYC = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_access_sequencer_if.master bus
);
    localparam int LANES   = DATA_W / 8;
    localparam int LSB_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int TMO_W   = $clog2(TIMEOUT + 1);
    localparam int BO_W    = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(LANES - 1);

    typedef enum logic [2:0] {S_IDLE, S_PTR, S_DATA, S_BACKOFF, S_DONE, S_ERR} state_t;

    state_t              state_reg, state_next;
    logic                indirect_reg, indirect_next;
    logic                we_reg, we_next;
    logic                byte_reg, byte_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [ADDR_W-1:0]   ptr_reg, ptr_next;
    logic                ptr_phase_reg, ptr_phase_next;
    logic [RETRY_W-1:0]  retry_reg, retry_next;
    logic [TMO_W-1:0]    wait_reg, wait_next;
    logic [BO_W-1:0]     bo_reg, bo_next;

    logic                stb_reg, stb_next;
    logic                bus_we_reg, bus_we_next;
    logic [ADDR_W-1:0]   adr_reg, adr_next;
    logic [LANES-1:0]    sel_reg, sel_next;
    logic [DATA_W-1:0]   dat_o_reg, dat_o_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                done_reg, error_reg;

    logic                issue;
    logic [ADDR_W-1:0]   data_adr;
    logic [7:0]          lane_bytes [LANES];
    logic [LSB_W-1:0]    rd_lane;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_bytes[gi] = bus.wb_DAT_I[gi*8 +: 8];
    end
    assign rd_lane = adr_reg[LSB_W-1:0];

    always_comb begin
        state_next     = state_reg;
        indirect_next  = indirect_reg;
        we_next        = we_reg;
        byte_next      = byte_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        ptr_next       = ptr_reg;
        ptr_phase_next = ptr_phase_reg;
        retry_next     = retry_reg;
        wait_next      = wait_reg;
        bo_next        = bo_reg;
        stb_next       = stb_reg;
        bus_we_next    = bus_we_reg;
        adr_next       = adr_reg;
        sel_next       = sel_reg;
        dat_o_next     = dat_o_reg;
        rdata_next     = rdata_reg;
        issue          = 1'b0;
        data_adr       = '0;

        case (state_reg)
            S_IDLE: begin
                if (bus.req_valid) begin
                    indirect_next  = bus.req_indirect;
                    we_next        = bus.req_we;
                    byte_next      = bus.req_byte;
                    addr_next      = bus.req_addr;
                    wdata_next     = bus.req_wdata;
                    ptr_phase_next = bus.req_indirect;
                    retry_next     = '0;
                    state_next     = bus.req_indirect ? S_PTR : S_DATA;
                    issue          = 1'b1;
                end
            end
            S_PTR, S_DATA: begin
                if (!stb_reg) begin
                    // the one idle strobe cycle after the pointer phase completes
                    issue = 1'b1;
                end else if (bus.wb_RTY) begin
                    stb_next = 1'b0;
                    if (int'(retry_reg) >= MAX_RETRY) begin
                        state_next = S_ERR;
                    end else begin
                        retry_next = retry_reg + RETRY_W'(1);
                        bo_next    = '0;
                        state_next = S_BACKOFF;
                    end
                end else if (bus.wb_ACK) begin
                    stb_next = 1'b0;
                    if (state_reg == S_PTR) begin
                        ptr_next       = bus.wb_DAT_I[ADDR_W-1:0];
                        ptr_phase_next = 1'b0;
                        retry_next     = '0;
                        wait_next      = '0;
                        state_next     = S_DATA;
                    end else begin
                        state_next = S_DONE;
                        if (we_reg)
                            rdata_next = '0;
                        else if (byte_reg)
                            rdata_next = DATA_W'(lane_bytes[rd_lane]);
                        else
                            rdata_next = bus.wb_DAT_I;
                    end
                end else if (int'(wait_reg) >= TIMEOUT - 1) begin
                    stb_next   = 1'b0;
                    state_next = S_ERR;
                end else begin
                    wait_next = wait_reg + TMO_W'(1);
                end
            end
            S_BACKOFF: begin
                if (int'(bo_reg) >= BACKOFF_CYC - 1) begin
                    state_next = ptr_phase_reg ? S_PTR : S_DATA;
                    issue      = 1'b1;
                end else begin
                    bo_next = bo_reg + BO_W'(1);
                end
            end
            S_DONE, S_ERR: begin
                if (!bus.stall)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        // Bus fields are rebuilt from the latched request so a re-issue repeats them exactly.
        if (issue) begin
            stb_next  = 1'b1;
            wait_next = '0;
            if (state_next == S_PTR) begin
                bus_we_next = 1'b0;
                adr_next    = addr_next & ~LANE_MASK;
                sel_next    = '1;
                dat_o_next  = '0;
            end else begin
                data_adr    = indirect_next ? ptr_next : addr_next;
                bus_we_next = we_next;
                adr_next    = data_adr;
                sel_next    = byte_next ? (LANES'(1) << data_adr[LSB_W-1:0]) : '1;
                dat_o_next  = byte_next ? {LANES{wdata_next[7:0]}} : wdata_next;
            end
        end

        if (state_next == S_ERR)
            rdata_next = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            indirect_reg  <= 1'b0;
            we_reg        <= 1'b0;
            byte_reg      <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            ptr_reg       <= '0;
            ptr_phase_reg <= 1'b0;
            retry_reg     <= '0;
            wait_reg      <= '0;
            bo_reg        <= '0;
            stb_reg       <= 1'b0;
            bus_we_reg    <= 1'b0;
            adr_reg       <= '0;
            sel_reg       <= '0;
            dat_o_reg     <= '0;
            rdata_reg     <= '0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            indirect_reg  <= indirect_next;
            we_reg        <= we_next;
            byte_reg      <= byte_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            ptr_reg       <= ptr_next;
            ptr_phase_reg <= ptr_phase_next;
            retry_reg     <= retry_next;
            wait_reg      <= wait_next;
            bo_reg        <= bo_next;
            stb_reg       <= stb_next;
            bus_we_reg    <= bus_we_next;
            adr_reg       <= adr_next;
            sel_reg       <= sel_next;
            dat_o_reg     <= dat_o_next;
            rdata_reg     <= rdata_next;
            done_reg      <= (state_next == S_DONE) || (state_next == S_ERR);
            error_reg     <= (state_next == S_ERR);
        end
    end

    assign bus.wb_CYC   = stb_reg;
    assign bus.wb_STB   = stb_reg;
    assign bus.wb_WE    = bus_we_reg;
    assign bus.wb_ADR   = adr_reg;
    assign bus.wb_SEL   = sel_reg;
    assign bus.wb_DAT_O = dat_o_reg;
    assign bus.rdata    = rdata_reg;
    assign bus.done     = done_reg;
    assign bus.error    = error_reg;
    assign bus.request_stall = (bus.req_valid && (state_reg == S_IDLE)) ||
                               (state_reg == S_PTR) || (state_reg == S_DATA) ||
                               (state_reg == S_BACKOFF);
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: stimulus queues expected bus issues and completions,
// a scripted memory slave answers each issue, and a monitor compares what the DUT presents.
module tb_mem_access_sequencer;
    logic clk;
    logic reset;

    mem_access_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_access_sequencer #(
        .ADDR_W(16), .DATA_W(16), .MAX_RETRY(4), .BACKOFF_CYC(2), .TIMEOUT(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [1:0]  sel;
        logic [15:0] dat;
        int          gap;   // STB-low cycles before this issue, -1 = unchecked
        int          len;   // STB-high cycles of this issue, -1 = unchecked
    } bus_exp_t;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
    } done_exp_t;

    typedef struct {
        int          wait_cyc;
        logic        ack;
        logic        rty;
        logic [15:0] dat;
    } resp_t;

    bus_exp_t  exp_bus_q[$];
    done_exp_t exp_done_q[$];
    resp_t     resp_q[$];

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void push_bus(input logic we, input logic [15:0] adr, input logic [1:0] sel,
                                     input logic [15:0] dat, input int gap, input int len);
        bus_exp_t e;
        e.we = we; e.adr = adr; e.sel = sel; e.dat = dat; e.gap = gap; e.len = len;
        exp_bus_q.push_back(e);
    endfunction

    function automatic void push_resp(input int w, input logic ack, input logic rty, input logic [15:0] dat);
        resp_t r;
        r.wait_cyc = w; r.ack = ack; r.rty = rty; r.dat = dat;
        resp_q.push_back(r);
    endfunction

    function automatic void push_done(input logic err, input logic [15:0] rdata);
        done_exp_t d;
        d.err = err; d.rdata = rdata;
        exp_done_q.push_back(d);
    endfunction

    // Scripted memory slave: one response entry per STB burst.
    bit    slv_active = 0;
    int    slv_cnt = 0;
    resp_t slv_r;
    initial begin
        bus.wb_ACK   = 1'b0;
        bus.wb_RTY   = 1'b0;
        bus.wb_DAT_I = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.wb_ACK = 1'b0;
            bus.wb_RTY = 1'b0;
            if (!bus.wb_STB) begin
                slv_active = 0;
            end else begin
                if (!slv_active) begin
                    slv_active = 1;
                    slv_cnt = 0;
                    if (resp_q.size() > 0) slv_r = resp_q.pop_front();
                    else begin
                        slv_r.wait_cyc = 0; slv_r.ack = 1'b1; slv_r.rty = 1'b0; slv_r.dat = 16'h0;
                    end
                end
                if (slv_cnt == slv_r.wait_cyc) begin
                    bus.wb_ACK   = slv_r.ack;
                    bus.wb_RTY   = slv_r.rty;
                    bus.wb_DAT_I = slv_r.dat;
                end
                slv_cnt++;
            end
        end
    end

    // Monitor: compares bus issues, strobe shape and completions against the queues.
    logic      mon_stb_prev = 1'b0;
    logic      mon_done_prev = 1'b0;
    int        mon_high = 0;
    int        mon_low = 0;
    bus_exp_t  mon_cur;
    done_exp_t mon_d;
    initial begin
        mon_cur.len = -1;
        forever begin
            @(negedge clk);
            check("cyc_eq_stb", bus.wb_CYC, bus.wb_STB);
            if (!bus.done) check("error_without_done", bus.error, 1'b0);
            if (bus.wb_STB && !mon_stb_prev) begin
                check("bus_exp_avail", exp_bus_q.size() > 0, 1'b1);
                if (exp_bus_q.size() > 0) begin
                    mon_cur = exp_bus_q.pop_front();
                    check("adr", bus.wb_ADR, mon_cur.adr);
                    check("sel", bus.wb_SEL, mon_cur.sel);
                    check("we", bus.wb_WE, mon_cur.we);
                    if (mon_cur.we) check("dat_o", bus.wb_DAT_O, mon_cur.dat);
                    if (mon_cur.gap >= 0) check("stb_gap", mon_low, mon_cur.gap);
                end else begin
                    mon_cur.len = -1;
                end
                mon_high = 1;
            end else if (bus.wb_STB) begin
                mon_high++;
            end else if (mon_stb_prev) begin
                if (mon_cur.len >= 0) check("stb_len", mon_high, mon_cur.len);
                mon_low = 1;
            end else begin
                mon_low++;
            end
            if (bus.done && !mon_done_prev) begin
                check("done_exp_avail", exp_done_q.size() > 0, 1'b1);
                if (exp_done_q.size() > 0) begin
                    mon_d = exp_done_q.pop_front();
                    check("error", bus.error, mon_d.err);
                    check("rdata", bus.rdata, mon_d.rdata);
                    check("req_stall_in_done", bus.request_stall, 1'b0);
                    txn_no++;
                    $display("txn %0d: error=%0d rdata=%h", txn_no, bus.error, bus.rdata);
                end
            end
            mon_stb_prev  = bus.wb_STB;
            mon_done_prev = bus.done;
        end
    end

    task automatic issue_req(input logic ind, input logic we, input logic byt,
                             input logic [15:0] addr, input logic [15:0] wdata, input bit keep_valid);
        bus.req_indirect = ind;
        bus.req_we       = we;
        bus.req_byte     = byt;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        #1;
        check("req_stall_idle", bus.request_stall, 1'b1);
        @(posedge clk);
        #1;
        if (!keep_valid) bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", bus.done, 1'b1);
    endtask

    task automatic leave_done();
        @(posedge clk);
        #1;
        check("done_clears", bus.done, 1'b0);
        check("error_clears", bus.error, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_indirect = 1'b0;
        bus.req_we = 1'b0;
        bus.req_byte = 1'b0;
        bus.req_addr = 16'h0;
        bus.req_wdata = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", bus.wb_CYC, 1'b0);
        check("rst_stb", bus.wb_STB, 1'b0);
        check("rst_we", bus.wb_WE, 1'b0);
        check("rst_adr", bus.wb_ADR, 16'h0);
        check("rst_sel", bus.wb_SEL, 2'b00);
        check("rst_dat_o", bus.wb_DAT_O, 16'h0);
        check("rst_rdata", bus.rdata, 16'h0);
        check("rst_done", bus.done, 1'b0);
        check("rst_error", bus.error, 1'b0);
        check("rst_req_stall", bus.request_stall, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // LDR word, ACK after 2 wait cycles
        push_resp(2, 1, 0, 16'hBEEF);
        push_bus(0, 16'h1234, 2'b11, 16'h0, -1, 3);
        push_done(0, 16'hBEEF);
        issue_req(0, 0, 0, 16'h1234, 16'h0, 0);
        wait_done(); leave_done();

        // LDI byte, pointer to odd address -> lane 1
        push_resp(0, 1, 0, 16'h3001);
        push_resp(0, 1, 0, 16'h00A5);
        push_bus(0, 16'h0100, 2'b11, 16'h0, -1, 1);
        push_bus(0, 16'h3001, 2'b10, 16'h0, 1, 1);
        push_done(0, 16'h0000);
        issue_req(1, 0, 1, 16'h0100, 16'h0, 0);
        wait_done(); leave_done();

        // LDI byte, unaligned pointer address is word-aligned on the bus; lane 0 read
        push_resp(1, 1, 0, 16'h3000);
        push_resp(0, 1, 0, 16'hC3A5);
        push_bus(0, 16'h0100, 2'b11, 16'h0, -1, 2);
        push_bus(0, 16'h3000, 2'b01, 16'h0, 1, 1);
        push_done(0, 16'h00A5);
        issue_req(1, 0, 1, 16'h0101, 16'h0, 0);
        wait_done(); leave_done();

        // STI byte: low byte replicated on both lanes
        push_resp(0, 1, 0, 16'h2000);
        push_resp(0, 1, 0, 16'hFFFF);
        push_bus(0, 16'h0200, 2'b11, 16'h0, -1, 1);
        push_bus(1, 16'h2000, 2'b01, 16'h5A5A, 1, 1);
        push_done(0, 16'h0000);
        issue_req(1, 1, 1, 16'h0200, 16'h125A, 0);
        wait_done(); leave_done();

        // STR word
        push_resp(0, 1, 0, 16'h1111);
        push_bus(1, 16'h4002, 2'b11, 16'hCAFE, -1, 1);
        push_done(0, 16'h0000);
        issue_req(0, 1, 0, 16'h4002, 16'hCAFE, 0);
        wait_done(); leave_done();

        // STB to odd address -> upper lane
        push_resp(0, 1, 0, 16'h0);
        push_bus(1, 16'h4003, 2'b10, 16'h7777, -1, 1);
        push_done(0, 16'h0000);
        issue_req(0, 1, 1, 16'h4003, 16'h0077, 0);
        wait_done(); leave_done();

        // RTY, then RTY+ACK together (counts as retry), then ACK
        push_resp(0, 0, 1, 16'h0);
        push_resp(1, 1, 1, 16'hDEAD);
        push_resp(0, 1, 0, 16'h1357);
        push_bus(0, 16'h0AAA, 2'b11, 16'h0, -1, 1);
        push_bus(0, 16'h0AAA, 2'b11, 16'h0, 2, 2);
        push_bus(0, 16'h0AAA, 2'b11, 16'h0, 2, 1);
        push_done(0, 16'h1357);
        issue_req(0, 0, 0, 16'h0AAA, 16'h0, 0);
        wait_done(); leave_done();

        // five RTYs exceed the retry limit
        for (int i = 0; i < 5; i++) begin
            push_resp(0, 0, 1, 16'h9999);
            push_bus(0, 16'h0300, 2'b11, 16'h0, (i == 0) ? -1 : 2, 1);
        end
        push_done(1, 16'h0000);
        issue_req(0, 0, 0, 16'h0300, 16'h0, 0);
        wait_done(); leave_done();

        // exactly MAX_RETRY retries in each phase still succeed
        for (int i = 0; i < 5; i++) begin
            push_resp(0, (i == 4), (i != 4), 16'h0600);
            push_bus(0, 16'h0500, 2'b11, 16'h0, (i == 0) ? -1 : 2, 1);
        end
        for (int i = 0; i < 5; i++) begin
            push_resp(0, (i == 4), (i != 4), 16'h4242);
            push_bus(0, 16'h0600, 2'b11, 16'h0, (i == 0) ? 1 : 2, 1);
        end
        push_done(0, 16'h4242);
        issue_req(1, 0, 0, 16'h0500, 16'h0, 0);
        wait_done(); leave_done();

        // no response: timeout after 8 strobe cycles
        push_resp(0, 0, 0, 16'h0);
        push_bus(0, 16'h0700, 2'b11, 16'h0, -1, 8);
        push_done(1, 16'h0000);
        issue_req(0, 0, 0, 16'h0700, 16'h0, 0);
        wait_done(); leave_done();

        // stall held across DONE with req_valid still high: result held, no re-issue
        bus.stall = 1'b1;
        push_resp(0, 1, 0, 16'h00FF);
        push_bus(0, 16'h0042, 2'b11, 16'h0, -1, 1);
        push_done(0, 16'h00FF);
        issue_req(0, 0, 0, 16'h0042, 16'h0, 1);
        wait_done();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_done_held", bus.done, 1'b1);
            check("stall_rdata_held", bus.rdata, 16'h00FF);
            check("stall_req_stall", bus.request_stall, 1'b0);
        end
        bus.req_valid = 1'b0;
        bus.stall = 1'b0;
        leave_done();

        // reset in the middle of a data phase
        push_resp(0, 0, 0, 16'h0);
        push_bus(0, 16'h0800, 2'b11, 16'h0, -1, -1);
        issue_req(0, 0, 0, 16'h0800, 16'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_stb_active", bus.wb_STB, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_cyc", bus.wb_CYC, 1'b0);
        check("rst_mid_stb", bus.wb_STB, 1'b0);
        check("rst_mid_done", bus.done, 1'b0);
        check("rst_mid_req_stall", bus.request_stall, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // normal access after reset
        push_resp(0, 1, 0, 16'h2468);
        push_bus(0, 16'h1236, 2'b11, 16'h0, -1, 1);
        push_done(0, 16'h2468);
        issue_req(0, 0, 0, 16'h1236, 16'h0, 0);
        wait_done(); leave_done();

        repeat (3) @(posedge clk);
        check("bus_q_drained", exp_bus_q.size(), 0);
        check("done_q_drained", exp_done_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
